// File: rtl/signed_bcd_conv.sv
// Serial double-dabble binary-to-BCD converter that produces 7-segment display codes (0-9, A = minus, F = blank).
// Define SIGNED_BCD_LZB_EN for leading-zero blanking with the minus sign placed next to the number.
module signed_bcd_conv #(
    parameter int WIDTH = 8,
    parameter int NDIG  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    din,
    input  logic                is_signed,
    output logic                busy,
    output logic                done,
    output logic [4*NDIG-1:0]   digits,
    output logic                ovf
);

    localparam int INT_DIG = (WIDTH + 2) / 3;
    localparam int EXT_DIG = (NDIG > INT_DIG) ? NDIG : INT_DIG;
    localparam int CW      = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FMT} state_e;

    state_e                 state_q;
    logic                   neg_q;
    logic [WIDTH-1:0]       mag_q;
    logic [4*INT_DIG-1:0]   acc_q;
    logic [CW-1:0]          cnt_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   ovf_q;
    logic [4*NDIG-1:0]      digits_q;

    logic [4*INT_DIG-1:0]   acc_adj;
    logic [4*EXT_DIG-1:0]   acc_ext;
    logic [4*NDIG-1:0]      digits_d;
    logic                   ovf_d;
    int                     msd;
    int                     need;

    assign busy   = busy_q;
    assign done   = done_q;
    assign ovf    = ovf_q;
    assign digits = digits_q;

    // Double-dabble correction: any digit of 5 or more becomes >= 8 so the next shift carries out.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < INT_DIG; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default before any conditional write, so no latch is inferred.
        acc_ext  = '0;
        digits_d = '1;
        msd      = 0;
        acc_ext[4*INT_DIG-1:0] = acc_q;
        for (int i = 0; i < INT_DIG; i++) begin
            if (acc_q[4*i +: 4] != 4'd0) begin
                msd = i;
            end
        end
        need  = msd + 1 + (neg_q ? 1 : 0);
        ovf_d = (need > NDIG);
        for (int p = 0; p < NDIG; p++) begin
`ifdef SIGNED_BCD_LZB_EN
            if (p <= msd) begin
                digits_d[4*p +: 4] = acc_ext[4*p +: 4];
            end else if (neg_q && (p == msd + 1)) begin
                digits_d[4*p +: 4] = 4'hA;
            end else begin
                digits_d[4*p +: 4] = 4'hF;
            end
`else
            if (neg_q && (p == NDIG - 1)) begin
                digits_d[4*p +: 4] = 4'hA;
            end else begin
                digits_d[4*p +: 4] = acc_ext[4*p +: 4];
            end
`endif
        end
        if (ovf_d) begin
            digits_d = '1;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            neg_q    <= 1'b0;
            mag_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            digits_q <= '1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        neg_q   <= is_signed & din[WIDTH-1];
                        mag_q   <= (is_signed & din[WIDTH-1]) ? (~din + WIDTH'(1)) : din;
                        acc_q   <= '0;
                        cnt_q   <= CW'(WIDTH);
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    {acc_q, mag_q} <= {acc_adj, mag_q} << 1;
                    cnt_q          <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= FMT;
                    end
                end
                FMT: begin
                    digits_q <= digits_d;
                    ovf_q    <= ovf_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_bcd_conv.sv
// Scoreboard bench for signed_bcd_conv: a 4-digit and a 3-digit instance share stimulus;
// expectations come from a decimal model and are compared when done pulses.
module tb_signed_bcd_conv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  din;
    logic        is_signed;
    logic        busy, done, ovf;
    logic [15:0] digits;
    logic        busy3, done3, ovf3;
    logic [11:0] digits3;

    logic [16:0] q4[$];
    logic [16:0] q3[$];
    int          n_cmp;
    int          n_err;
    int          done_seen;

    signed_bcd_conv #(.WIDTH(8), .NDIG(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .is_signed(is_signed),
        .busy(busy), .done(done), .digits(digits), .ovf(ovf)
    );

    signed_bcd_conv #(.WIDTH(8), .NDIG(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .is_signed(is_signed),
        .busy(busy3), .done(done3), .digits(digits3), .ovf(ovf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns {ovf, digits}; positions above nd are left as F.
    function automatic logic [16:0] model(input logic [7:0] d, input logic s, input int nd);
        logic        n;
        int          mag;
        int          need;
        int          pw;
        logic [15:0] r;
        n    = s & d[7];
        mag  = n ? (256 - int'(d)) : int'(d);
        need = (mag >= 100) ? 3 : (mag >= 10) ? 2 : 1;
        r    = 16'hFFFF;
        if (need + (n ? 1 : 0) > nd) return {1'b1, 16'hFFFF};
        pw = 1;
        for (int p = 0; p < nd; p++) begin
`ifdef SIGNED_BCD_LZB_EN
            if (p < need)                r[4*p +: 4] = 4'((mag / pw) % 10);
            else if (n && p == need)     r[4*p +: 4] = 4'hA;
            else                         r[4*p +: 4] = 4'hF;
`else
            if (n && p == nd - 1)        r[4*p +: 4] = 4'hA;
            else                         r[4*p +: 4] = 4'((mag / pw) % 10);
`endif
            pw = pw * 10;
        end
        return {1'b0, r};
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            done_seen++;
            if (q4.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("result_ndig4", {15'd0, ovf, digits}, {15'd0, q4.pop_front()});
            end
            if (q3.size() == 0) begin
                check("unexpected_done3", 32'd1, 32'd0);
            end else begin
                check("result_ndig3", {15'd0, ovf3, 4'hF, digits3}, {15'd0, q3.pop_front()});
            end
        end
    end

    // Called just after an edge: raises start for the next edge and records the expectation.
    task automatic issue(input logic [7:0] d, input logic s);
        start     = 1'b1;
        din       = d;
        is_signed = s;
        q4.push_back(model(d, s, 4));
        q3.push_back(model(d, s, 3));
    endtask

    // Walks edges T, T+1, ... after issue; optionally pulses start at cycles ign_a/ign_b.
    task automatic wait_done(input int ign_a, input int ign_b);
        int   k;
        logic got;
        logic busy_ok;
        got     = 1'b0;
        busy_ok = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            din   = 8'($urandom);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (k == ign_a || k == ign_b) begin
                start     = 1'b1;
                din       = 8'h37;
                is_signed = 1'b0;
            end
        end
        check("latency", got ? 32'(k) : 32'd999, 32'd9);
        check("busy_during", {31'd0, busy_ok}, 32'd1);
        check("busy_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        done_seen = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        din       = '0;
        is_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_ovf", {31'd0, ovf}, 32'd0);
        check("reset_digits", {16'd0, digits}, 32'h0000FFFF);
        check("reset_digits3", {20'd0, digits3}, 32'h00000FFF);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        issue(8'hFB, 1'b1); wait_done(-1, -1);
        issue(8'h80, 1'b1); wait_done(-1, -1);
        issue(8'h80, 1'b0); wait_done(-1, -1);
        issue(8'hFF, 1'b0); wait_done(-1, -1);
        issue(8'h00, 1'b1); wait_done(-1, -1);
        issue(8'h63, 1'b1); wait_done(-1, -1);
        issue(8'h9C, 1'b1); wait_done(-1, -1);
        for (int i = 0; i < 6; i++) begin
            repeat (2) @(posedge clk);
            #1;
            issue(8'($urandom), 1'($urandom));
            wait_done(-1, -1);
        end

        // Starts during a conversion must be ignored.
        repeat (2) @(posedge clk);
        #1;
        issue(8'h2A, 1'b1);
        wait_done(2, 5);
        repeat (12) @(posedge clk);
        #1;
        check("ignored_start_no_extra", 32'(q4.size()), 32'd0);

        // Start in the done cycle is accepted.
        issue(8'hC8, 1'b1);
        wait_done(-1, -1);
        issue(8'h07, 1'b0);
        wait_done(-1, -1);

        // Asynchronous abort mid-conversion.
        repeat (2) @(posedge clk);
        #1;
        issue(8'h55, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_digits", {16'd0, digits}, 32'h0000FFFF);
        void'(q4.pop_back());
        void'(q3.pop_back());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        begin
            int base;
            base = done_seen;
            repeat (15) @(posedge clk);
            #1;
            check("no_done_after_abort", 32'(done_seen), 32'(base));
        end
        issue(8'hF6, 1'b1);
        wait_done(-1, -1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(q4.size() + q3.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/signed_bcd_conv.md
Name: signed_bcd_conv

Overview:
- Sequential binary-to-BCD converter sitting directly upstream of the per-digit seven-segment decoders.
- Takes a WIDTH-bit ALU result, signed or unsigned, and converts it serially by double-dabble, one bit per cycle.
- Emits NDIG packed 4-bit display codes. Each code is 0-9 for a digit, 10 for minus, 15 for blank, so each nibble drives one seven-segment decoder directly.

Parameters:
- WIDTH, 8, input operand width in bits (≥2).
- NDIG, 4, number of display digit positions produced (≥2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; samples din/is_signed when idle.
- din  input  WIDTH  operand.
- is_signed  input  1  1 = din is two's complement; 0 = unsigned.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when digits are updated.
- digits  output  4*NDIG  display codes; digit 0 (least significant) is in [3:0].
- ovf  output  1  result does not fit NDIG positions; valid with digits.

Behaviour:
- Reset (async assert, sync to clk on release):
  - busy=0, done=0, ovf=0.
  - digits = all 4'hF (blank display).
  - FSM goes to IDLE.
- Internal BCD accumulator: INT_DIG = (WIDTH+2)/3 digits, enough for any WIDTH-bit magnitude.
- State IDLE:
  - start=1 at edge T latches neg = is_signed & din[WIDTH-1].
  - Latches mag = neg ? (~din+1) : din, as WIDTH-bit unsigned. Most-negative input yields 2^(WIDTH-1); no saturation.
  - Clears the accumulator, loads the bit counter with WIDTH, sets busy=1, and moves to SHIFT.
- State SHIFT:
  - Each edge: every accumulator digit ≥5 gets +3.
  - Then {acc,mag} shifts left by 1 and the counter decrements.
  - After exactly WIDTH shift edges (T+1..T+WIDTH), moves to FMT.
- State FMT (edge T+WIDTH+1):
  - Registers digits and ovf, pulses done=1 for the following cycle, clears busy, and returns to IDLE.
  - Latency from start edge to digits valid: WIDTH+1 cycles. The next start is accepted in the cycle done is high.
- Formatting (BLANK_EN defined):
  - m = index of the most significant non-zero accumulator digit; m=0 if the value is zero.
  - Positions 0..m hold the BCD digits.
  - If neg, position m+1 holds 4'hA.
  - All higher positions hold 4'hF.
  - Zero displays as a single "0"; negative zero cannot occur.
- Overflow: required positions (m+1, plus 1 if neg) > NDIG:
  - ovf=1 and digits = all 4'hF.
  - Otherwise ovf=0.
- start while busy=1 is ignored; no queueing. din/is_signed are don't-care after the start edge.
- digits/ovf hold their last value until the next FMT. They do not change during SHIFT.
- rst_n asserted mid-conversion aborts immediately with reset values; no done pulse.

Optional Feature:
- Macro SIGNED_BCD_LZB_EN controls leading-zero blanking. The blanking and sign-adjacent placement described under Behaviour apply when it is defined.
- When not defined:
  - Leading positions show 4'h0 rather than blank.
  - For negative results the minus (4'hA) always occupies position NDIG-1.
  - Overflow condition becomes: accumulator needs more than NDIG-1 digits when neg, or more than NDIG digits otherwise.

Test Plan:
- WIDTH=8, NDIG=4, is_signed=1, din=8'hFB (-5):
  - done exactly 9 cycles after the start edge; digits=16'hFFA5, ovf=0.
  - Without macro: 16'hA005.
- din=8'h80 signed → digits=16'hA128. din=8'h80 unsigned → 16'hF128. din=8'hFF unsigned → 16'hF255. din=0 → 16'hFFF0.
- NDIG=3, din=8'h80 signed → ovf=1, digits=12'hFFF. Same din unsigned → 12'h128, ovf=0.
- start pulsed again at cycles 2 and 5 of a conversion with a different din → ignored; result matches the first operand; busy stays high for 9 cycles total.
- start re-asserted in the done cycle → accepted; second result follows 9 cycles later.
- rst_n low at cycle 4 of a conversion → busy=0, done=0, digits=all F immediately (async). No done pulse after release until a new start.
